// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM states and op-classification helpers for the EX-stage mul/div unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MADD  = 3'd2;
  localparam logic [2:0] OP_MADDU = 3'd3;
  localparam logic [2:0] OP_MSUB  = 3'd4;
  localparam logic [2:0] OP_MSUBU = 3'd5;
  localparam logic [2:0] OP_DIV   = 3'd6;
  localparam logic [2:0] OP_DIVU  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_acc_op(input logic [2:0] op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_sub_op(input logic [2:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shared shift-add multiplier / restoring divider with sign fix-up and HI/LO accumulate.
// Latency: one bit per step; fix-up is combinational and captured by res_ld.
// Backpressure: none; the controlling FSM sequences load/step/acc_en/res_ld.
// Build option EX_MULDIV_EARLY_TERM_EN: early_done_o flags a multiply whose remaining multiplier bits are zero.
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               acc_en,
  input  logic               res_ld,
  input  logic               res_zero,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  input  logic [2*WIDTH-1:0] hilo_i,
  output logic [2:0]         op_o,
  output logic               early_done_o,
  output logic [2*WIDTH-1:0] result_o
);
  import muldiv_pkg::*;

  localparam int W2 = 2 * WIDTH;

  logic [2:0]       op_q;
  logic             sa_q, sb_q;
  logic [W2-1:0]    acc_q, mcand_q, hilo_q, res_q;
  logic [WIDTH-1:0] mplr_q;

  logic             signed_in, a_neg, b_neg, op_is_div;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_diff, rem_nxt, quo_nxt;
  logic [W2-1:0]    mul_nxt;
  logic             neg;
  logic [W2-1:0]    prod_fix, accum, fin;
  logic [WIDTH-1:0] rem_fix, quo_fix;

  // Operand conditioning at accept: magnitudes plus sign flags for signed ops.
  always_comb begin
    signed_in = is_signed_op(op_i);
    op_is_div = is_div_op(op_i);
    a_neg     = signed_in & opa_i[WIDTH-1];
    b_neg     = signed_in & opb_i[WIDTH-1];
    abs_a     = a_neg ? -opa_i : opa_i;
    abs_b     = b_neg ? -opb_i : opb_i;
  end

  // One iteration of each algorithm; divide keeps {rem, dividend/quotient} in acc_q.
  always_comb begin
    rem_sh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    rem_ge   = rem_sh >= {1'b0, mcand_q[WIDTH-1:0]};
    rem_diff = rem_sh[WIDTH-1:0] - mcand_q[WIDTH-1:0];
    rem_nxt  = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
    quo_nxt  = {acc_q[WIDTH-2:0], rem_ge};
    mul_nxt  = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  // Sign fix-up, accumulate and final result selection.
  always_comb begin
    neg      = sa_q ^ sb_q;
    prod_fix = neg ? -acc_q : acc_q;
    quo_fix  = neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = sa_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
    accum    = is_sub_op(op_q) ? (hilo_q - prod_fix) : (hilo_q + prod_fix);
    if (is_acc_op(op_q)) begin
      fin = acc_q;
    end else if (is_div_op(op_q)) begin
      fin = {rem_fix, quo_fix};
    end else begin
      fin = prod_fix;
    end
  end

  // Working registers: load at accept, iterate in CALC, accumulate in ACC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= OP_MULT;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      hilo_q  <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
    end else if (load) begin
      op_q    <= op_i;
      sa_q    <= a_neg;
      sb_q    <= b_neg;
      hilo_q  <= hilo_i;
      mplr_q  <= op_is_div ? '0 : abs_b;
      acc_q   <= op_is_div ? {{WIDTH{1'b0}}, abs_a} : '0;
      mcand_q <= op_is_div ? {{WIDTH{1'b0}}, abs_b} : {{WIDTH{1'b0}}, abs_a};
    end else if (step) begin
      if (is_div_op(op_q)) begin
        acc_q <= {rem_nxt, quo_nxt};
      end else begin
        acc_q   <= mul_nxt;
        mcand_q <= mcand_q << 1;
        mplr_q  <= mplr_q >> 1;
      end
    end else if (acc_en) begin
      acc_q <= accum;
    end
  end

  // Result register: held stable for the whole DONE handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q <= '0;
    end else if (res_ld) begin
      res_q <= res_zero ? '0 : fin;
    end
  end

`ifdef EX_MULDIV_EARLY_TERM_EN
  assign early_done_o = ~is_div_op(op_q) & (mplr_q[WIDTH-1:1] == '0);
`else
  assign early_done_o = 1'b0;
`endif

  assign op_o     = op_q;
  assign result_o = res_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MADD/MSUB/DIV engine for EX: one shared shift-add / restoring-divide datapath.
// Latency: WIDTH+1 (mul/div), WIDTH+2 (MADD/MSUB), 1 (divide by zero) from accept to ready_o.
// Backpressure: EX holds start_i until ready_o; DONE holds the result until start_i drops. Option: EX_MULDIV_EARLY_TERM_EN.
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  input  logic [2*WIDTH-1:0] hilo_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_zero_o
);
  import muldiv_pkg::*;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             dz_q, dz_d;
  logic             dp_load, dp_step, dp_acc, dp_res_ld, dp_res_zero;
  logic [2:0]       op_q;
  logic             early_done;
  logic             calc_last;

  assign calc_last = (cnt_q == CNT_W'(WIDTH - 1)) | early_done;

  // Next-state and datapath strobes; annul overrides everything, including a new start.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    dz_d        = dz_q;
    dp_load     = 1'b0;
    dp_step     = 1'b0;
    dp_acc      = 1'b0;
    dp_res_ld   = 1'b0;
    dp_res_zero = 1'b0;
    if (annul_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ready_d = 1'b0;
      dz_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            dp_load = 1'b1;
            cnt_d   = '0;
            if (is_div_op(op_i) && (opb_i == '0)) begin
              state_d = ST_DONE;
              dz_d    = 1'b1;
            end else begin
              state_d = ST_CALC;
              dz_d    = 1'b0;
            end
          end
        end
        ST_CALC: begin
          dp_step = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (calc_last) begin
            state_d = is_acc_op(op_q) ? ST_ACC : ST_DONE;
          end
        end
        ST_ACC: begin
          dp_acc  = 1'b1;
          state_d = ST_DONE;
        end
        ST_DONE: begin
          // First DONE cycle captures the fixed-up result; later cycles just hold it.
          if (!ready_q) begin
            ready_d     = 1'b1;
            dp_res_ld   = 1'b1;
            dp_res_zero = dz_q;
          end else if (!start_i) begin
            state_d = ST_IDLE;
            ready_d = 1'b0;
            dz_d    = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      dz_q    <= dz_d;
    end
  end

  muldiv_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk          (clk),
    .rst          (rst),
    .load         (dp_load),
    .step         (dp_step),
    .acc_en       (dp_acc),
    .res_ld       (dp_res_ld),
    .res_zero     (dp_res_zero),
    .op_i         (op_i),
    .opa_i        (opa_i),
    .opb_i        (opb_i),
    .hilo_i       (hilo_i),
    .op_o         (op_q),
    .early_done_o (early_done),
    .result_o     (result_o)
  );

  assign busy_o     = (state_q == ST_CALC) || (state_q == ST_ACC);
  assign ready_o    = ready_q;
  assign div_zero_o = ready_q & dz_q;

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Parametrised iterative multiply / multiply-accumulate / divide engine serving the EX stage.
- Replaces the single-cycle multiplier, the two-pass MADD/MSUB sequencing and the separate divider with one shared shift-add / restoring-divide datapath.
- EX holds `start_i` high and stalls while `busy_o` is high; the result is consumed on `ready_o` and written to HI/LO.

Parameters:
- `WIDTH`, 32, operand width; result is 2*WIDTH as {hi, lo}.
- `CNT_W`, $clog2(WIDTH)+1, iteration counter width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  request; held high by EX until `ready_o` is seen.
- `annul_i`  in  1  cancel the operation in flight (flush/exception).
- `op_i`  in  3  operation code from shared package: MULT, MULTU, MADD, MADDU, MSUB, MSUBU, DIV, DIVU.
- `opa_i`  in  WIDTH  rs operand; dividend for divides.
- `opb_i`  in  WIDTH  rt operand; divisor for divides.
- `hilo_i`  in  2*WIDTH  forwarded {HI, LO}; used by MADD/MSUB only.
- `busy_o`  out  1  operation in progress.
- `ready_o`  out  1  `result_o` valid.
- `result_o`  out  2*WIDTH  multiplies: {hi, lo} = product or accumulation; divides: {remainder, quotient}.
- `div_zero_o`  out  1  divisor was zero; valid while `ready_o` is high.

Behaviour:
- Reset (rst=0, async): state IDLE; `busy_o`, `ready_o` and `div_zero_o` = 0; `result_o` = 0; counter = 0.
- IDLE:
  - On `start_i`=1 and `annul_i`=0, register op, |a|, |b|, sign flags (signed ops only) and `hilo_i`.
  - Divide with `opb_i`=0: go to DONE, result 0, `div_zero_o`=1.
  - Otherwise go to CALC with counter=0.
- CALC: one bit per cycle for exactly WIDTH cycles.
  - Multiply: add multiplicand if multiplier LSB is 1, shift right.
  - Divide: restoring shift-subtract; quotient bit = no-borrow.
- After CALC:
  - Multiply result is negated when sign_a^sign_b (signed ops).
  - Divide: quotient negated when sign_a^sign_b; remainder takes the sign of the dividend.
  - MULT/MULTU/DIV/DIVU go to DONE.
  - MADD*/MSUB* go to ACC.
- ACC (1 cycle): result = hilo + product (MADD*) or hilo − product (MSUB*), modulo 2^(2*WIDTH); then DONE.
- DONE:
  - `ready_o`=1 and `result_o` stable.
  - Stays in DONE while `start_i`=1; returns to IDLE the cycle after `start_i`=0.
  - `ready_o` drops with the transition.
- Latency from the accept edge to `ready_o` high:
  - MULT/DIV: WIDTH+1 cycles.
  - MADD/MSUB: WIDTH+2 cycles.
  - Divide by zero: 1 cycle.
- `busy_o` = 1 in CALC and ACC only.
- `annul_i`=1 in any state returns to IDLE next cycle: `busy_o`=0, `ready_o`=0, `div_zero_o`=0, no result. A `start_i` in that same cycle is ignored.
- Signed MIN / −1: quotient = MIN (wraps), remainder = 0, no flag.
- Inputs are sampled only at accept; input changes during CALC have no effect.
- `rst` asserted mid-operation aborts immediately to the reset state.

Optional Feature:
- Macro `EX_MULDIV_EARLY_TERM_EN`.
- Defined: a multiply leaves CALC as soon as the remaining multiplier bits are all zero (minimum 1 CALC cycle). Latency becomes k+1 (or k+2 with ACC), where k = index of the highest set bit of |b| plus 1. Divide latency is unchanged.
- Undefined: fixed latency as stated in Behaviour.

Decomposition:
- Shared package (`muldiv_pkg`):
  - `op_i` encodings;
  - state enum IDLE/CALC/ACC/DONE;
  - helper `is_signed_op`, `is_div_op` and `is_acc_op` functions.
- One natural sub-module, `muldiv_datapath`: shift registers, adder/subtractor and sign fix-up, driven by the FSM in `ex_muldiv_unit`.

Test Plan:
- MULT, a=0xFFFFFFFE, b=3 → `result_o`=0xFFFFFFFF_FFFFFFFA; `ready_o` 33 cycles after accept.
- MADDU, `hilo_i`=0x00000000_00000010, a=0xFFFFFFFF, b=2 → `result_o`=0x00000002_0000000E; `ready_o` 34 cycles after accept.
- MSUB, `hilo_i`=0, a=5, b=3 → 0xFFFFFFFF_FFFFFFF1. DIV, a=0xFFFFFFF9, b=2 → {0xFFFFFFFF, 0xFFFFFFFD}.
- DIVU, b=0 → `ready_o` 1 cycle after accept, `div_zero_o`=1, `result_o`=0. DIV 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}.
- `annul_i` pulsed 10 cycles into a DIVU → `busy_o`=0 next cycle and `ready_o` never asserts; the following MULTU 7×6 returns 0x00000000_0000002A.
- Handshake: hold `start_i` 5 cycles past `ready_o` → `ready_o` and `result_o` stay stable; `ready_o`=0 one cycle after `start_i` falls. With `EX_MULDIV_EARLY_TERM_EN` defined, MULTU 7×6 completes in 4 cycles.
